// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared types and helpers for the sequential neuron family.
//   state_e      : controller states of the time-multiplexed MAC neuron
//   act_mode_e   : activation selection (ReLU or linear, both saturating)
//   acc_width    : accumulator width for a given data width / input count
//   idx_width    : input-index counter width (at least one bit)
//   sat_to_width : clamps a wide signed value into a DATA_WIDTH signed range
// -----------------------------------------------------------------------------
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    ACT_RELU   = 1'b0,
    ACT_LINEAR = 1'b1
  } act_mode_e;

  // Working width of the saturation helper; any accumulator is sign-extended
  // up to this before clamping.
  localparam int SAT_W = 32'sd128;

  // Full product width plus one bit per doubling of the term count plus a
  // guard bit for the bias.
  function automatic int acc_width(input int dw, input int n_inputs);
    return (32'sd2 * dw) + $clog2(n_inputs) + 32'sd1;
  endfunction

  // A single-input neuron still needs a one-bit index register.
  function automatic int idx_width(input int n_inputs);
    if (n_inputs > 32'sd1) begin
      return $clog2(n_inputs);
    end else begin
      return 32'sd1;
    end
  endfunction

  // Clamp acc to [-2^(dw-1), 2^(dw-1)-1]; the caller keeps the low dw bits.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] acc,
    input int                      dw
  );
    logic signed [SAT_W-1:0] one_s;
    logic signed [SAT_W-1:0] max_s;
    logic signed [SAT_W-1:0] min_s;
    one_s = {{(SAT_W-1){1'b0}}, 1'b1};
    max_s = (one_s <<< (dw - 32'sd1)) - one_s;
    min_s = ~max_s;
    if (acc > max_s) begin
      return max_s;
    end else if (acc < min_s) begin
      return min_s;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// -----------------------------------------------------------------------------
// neuron_act_sat
// Combinational activation + saturation from a wide accumulator to a
// DATA_WIDTH signed result.
//   acc : signed accumulator, ACC_W bits, already in output fixed-point format
//   y   : signed activated and saturated result, DATA_WIDTH bits
// ACT_MODE 0 = ReLU (non-positive -> 0, clamp at MAX), 1 = linear (clamp to
// [MIN, MAX]).
// -----------------------------------------------------------------------------
module neuron_act_sat
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 32'sd8,
  parameter int ACC_W      = 32'sd20,
  parameter int ACT_MODE   = 32'sd0
) (
  input  logic signed [ACC_W-1:0]      acc,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam act_mode_e MODE_E = (ACT_MODE == 32'sd1) ? ACT_LINEAR : ACT_RELU;

  logic signed [DATA_WIDTH-1:0] sat_s;

  // Clamp the accumulator, then apply the selected activation.
  always_comb begin
    sat_s = DATA_WIDTH'(sat_to_width({{(SAT_W-ACC_W){acc[ACC_W-1]}}, acc}, DATA_WIDTH));
    y     = sat_s;
    case (MODE_E)
      ACT_LINEAR: begin
        y = sat_s;
      end
      ACT_RELU: begin
        if (acc[ACC_W-1]) begin
          y = {DATA_WIDTH{1'b0}};
        end else begin
          y = sat_s;
        end
      end
      default: begin
        y = sat_s;
      end
    endcase
  end

endmodule

// File: rtl/neuron_seq_mac.sv
// -----------------------------------------------------------------------------
// neuron_seq_mac
// One fully-connected neuron over N_INPUTS signed fixed-point inputs with
// compile-time weights and bias, computed with a single shared multiplier,
// followed by a saturating activation and a valid/ready result handshake.
//   clk     : clock
//   rst     : synchronous active-high reset (overrides En)
//   En      : global enable; low freezes every register
//   start   : capture X and begin a computation (only honoured in IDLE)
//   X       : packed signed inputs, X[i] at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy    : high whenever the controller is not IDLE
//   Y       : signed result, held until the next result or reset
//   y_valid : Y holds a completed result
//   y_ready : downstream accepts Y
// -----------------------------------------------------------------------------
module neuron_seq_mac
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = 32'sd8,
  parameter int FRAC_BITS  = 32'sd4,
  parameter int N_INPUTS   = 32'sd6,
  parameter logic [N_INPUTS*DATA_WIDTH-1:0] WEIGHTS = {(N_INPUTS*DATA_WIDTH){1'b0}},
  parameter logic signed [DATA_WIDTH-1:0]   BIAS    = {DATA_WIDTH{1'b0}},
  parameter int ACT_MODE   = 32'sd0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           En,
  input  logic                           start,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] X,
  output logic                           busy,
  output logic signed [DATA_WIDTH-1:0]   Y,
  output logic                           y_valid,
  input  logic                           y_ready
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, N_INPUTS);
  localparam int IDX_W  = idx_width(N_INPUTS);
  localparam int PROD_W = 32'sd2 * DATA_WIDTH;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 32'sd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic signed [ACC_W-1:0] BIAS_EXT =
    {{(ACC_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};

  state_e                         state_r, state_nxt_s;
  logic [IDX_W-1:0]               idx_r, idx_nxt_s;
  logic signed [ACC_W-1:0]        acc_r, acc_nxt_s;
  logic [N_INPUTS*DATA_WIDTH-1:0] x_r, x_nxt_s;
  logic signed [DATA_WIDTH-1:0]   y_r, y_nxt_s;
  logic                           y_valid_r, y_valid_nxt_s;
  logic                           busy_r, busy_nxt_s;

  int                             sel_s;
  logic signed [DATA_WIDTH-1:0]   x_sel_s;
  logic signed [DATA_WIDTH-1:0]   w_sel_s;
  logic signed [PROD_W-1:0]       prod_s;
  logic signed [PROD_W-1:0]       term_s;
  logic signed [ACC_W-1:0]        term_ext_s;
  logic signed [DATA_WIDTH-1:0]   act_y_s;

  // Operand select and product term. The operands are sign-extended to the
  // full product width so the low PROD_W bits are the exact signed product;
  // the arithmetic shift then floors it (e.g. -762 >>> 4 = -48, not -47).
  always_comb begin
    sel_s      = int'(idx_r) * DATA_WIDTH;
    x_sel_s    = x_r[sel_s +: DATA_WIDTH];
    w_sel_s    = WEIGHTS[sel_s +: DATA_WIDTH];
    prod_s     = {{DATA_WIDTH{x_sel_s[DATA_WIDTH-1]}}, x_sel_s} *
                 {{DATA_WIDTH{w_sel_s[DATA_WIDTH-1]}}, w_sel_s};
    term_s     = prod_s >>> FRAC_BITS;
    term_ext_s = {{(ACC_W-PROD_W){term_s[PROD_W-1]}}, term_s};
  end

  neuron_act_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W),
    .ACT_MODE   (ACT_MODE)
  ) u_act_sat (
    .acc (acc_r),
    .y   (act_y_s)
  );

  // Next-state and next-datapath logic; every register holds by default.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    acc_nxt_s     = acc_r;
    x_nxt_s       = x_r;
    y_nxt_s       = y_r;
    y_valid_nxt_s = y_valid_r;
    if (En) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x_nxt_s     = X;
            acc_nxt_s   = BIAS_EXT;
            idx_nxt_s   = {IDX_W{1'b0}};
            state_nxt_s = MAC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        MAC: begin
          acc_nxt_s = acc_r + term_ext_s;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s   = {IDX_W{1'b0}};
            state_nxt_s = ACT;
          end else begin
            idx_nxt_s   = idx_r + IDX_ONE;
            state_nxt_s = MAC;
          end
        end
        ACT: begin
          y_nxt_s       = act_y_s;
          y_valid_nxt_s = 1'b1;
          state_nxt_s   = DONE;
        end
        DONE: begin
          // A start seen here is deliberately dropped; it must be re-presented.
          if (y_ready) begin
            y_valid_nxt_s = 1'b0;
            state_nxt_s   = IDLE;
          end else begin
            state_nxt_s   = DONE;
          end
        end
        default: begin
          y_valid_nxt_s = 1'b0;
          idx_nxt_s     = {IDX_W{1'b0}};
          state_nxt_s   = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    if (state_nxt_s != IDLE) begin
      busy_nxt_s = 1'b1;
    end else begin
      busy_nxt_s = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      x_r       <= {(N_INPUTS*DATA_WIDTH){1'b0}};
      y_r       <= {DATA_WIDTH{1'b0}};
      y_valid_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      acc_r     <= acc_nxt_s;
      x_r       <= x_nxt_s;
      y_r       <= y_nxt_s;
      y_valid_r <= y_valid_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  assign Y       = y_r;
  assign y_valid = y_valid_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_seq_mac
// Four instances: 6-input ReLU and linear sharing X6, and 1-input ReLU and
// linear sharing X1. Weights are {8,-6,-7,8,14,10} for inputs 0..5, bias 5;
// the single-input neuron uses weight 16, bias 0.
// -----------------------------------------------------------------------------
module tb_neuron_seq_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, start6, start1, ready6, ready1;
  logic [47:0] x6;
  logic [7:0]  x1;
  logic signed [7:0] y6r, y6l, y1r, y1l;
  logic v6r, v6l, v1r, v1l, b6r, b6l, b1r, b1l;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] x;
    int          exp_relu;
    int          exp_lin;
  } vec_t;

  vec_t tbl [8];

  neuron_seq_mac #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(6),
    .WEIGHTS({8'h0A, 8'h0E, 8'h08, 8'hF9, 8'hFA, 8'h08}), .BIAS(8'sd5), .ACT_MODE(0))
  dut6r (.clk(clk), .rst(rst), .En(en), .start(start6), .X(x6), .busy(b6r),
         .Y(y6r), .y_valid(v6r), .y_ready(ready6));

  neuron_seq_mac #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(6),
    .WEIGHTS({8'h0A, 8'h0E, 8'h08, 8'hF9, 8'hFA, 8'h08}), .BIAS(8'sd5), .ACT_MODE(1))
  dut6l (.clk(clk), .rst(rst), .En(en), .start(start6), .X(x6), .busy(b6l),
         .Y(y6l), .y_valid(v6l), .y_ready(ready6));

  neuron_seq_mac #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(1),
    .WEIGHTS(8'h10), .BIAS(8'sd0), .ACT_MODE(0))
  dut1r (.clk(clk), .rst(rst), .En(en), .start(start1), .X(x1), .busy(b1r),
         .Y(y1r), .y_valid(v1r), .y_ready(ready1));

  neuron_seq_mac #(.DATA_WIDTH(8), .FRAC_BITS(4), .N_INPUTS(1),
    .WEIGHTS(8'h10), .BIAS(8'sd0), .ACT_MODE(1))
  dut1l (.clk(clk), .rst(rst), .En(en), .start(start1), .X(x1), .busy(b1l),
         .Y(y1l), .y_valid(v1l), .y_ready(ready1));

  function automatic logic [47:0] pack6(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a2, input logic [7:0] a3,
                                        input logic [7:0] a4, input logic [7:0] a5);
    return {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic start6_pulse(input logic [47:0] x);
    x6 = x;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    x6 = 48'h5A5A_A5A5_5A5A;
  endtask

  task automatic wait_valid6(output int edges);
    edges = 0;
    while (v6r !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // One full 6-input transaction with y_ready high.
  task automatic run6(input vec_t v);
    int e;
    start6_pulse(v.x);
    check("busy_after_capture", 32'(b6r), 32'sd1);
    check("no_early_valid", 32'(v6r), 32'sd0);
    wait_valid6(e);
    check("latency6", e, 32'sd7);
    check("y6_relu", 32'(y6r), v.exp_relu);
    check("y6_linear", 32'(y6l), v.exp_lin);
    check("valid6_linear", 32'(v6l), 32'sd1);
    @(negedge clk);
    check("valid6_drop", 32'(v6r), 32'sd0);
    check("busy6_idle", 32'(b6r), 32'sd0);
    check("y6_hold_after_ack", 32'(y6r), v.exp_relu);
  endtask

  task automatic run1(input logic [7:0] x, input int er, input int el);
    int e;
    x1 = x;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    x1 = 8'h33;
    e = 0;
    while (v1r !== 1'b1 && e < 20) begin
      @(negedge clk);
      e++;
    end
    check("latency1", e, 32'sd2);
    check("y1_relu", 32'(y1r), er);
    check("y1_linear", 32'(y1l), el);
    @(negedge clk);
    check("valid1_drop", 32'(v1r), 32'sd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic stable;

    tbl[0] = '{pack6(8'd16, 8'd16, 8'd16, 8'd16, 8'd16, 8'd16), 32, 32};
    tbl[1] = '{pack6(8'd0, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0), 0, -43};
    tbl[2] = '{pack6(8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127), 127, 127};
    tbl[3] = '{pack6(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80), 0, -128};
    tbl[4] = '{pack6(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6), 11, 11};
    tbl[5] = '{pack6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 1, 1};
    tbl[6] = '{pack6(8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0), 0, -22};
    tbl[7] = '{pack6(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 5, 5};

    rst = 1'b1; en = 1'b1; start6 = 1'b0; start1 = 1'b0;
    ready6 = 1'b1; ready1 = 1'b1; x6 = 48'd0; x1 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_y6", 32'(y6r), 32'sd0);
    check("reset_valid6", 32'(v6r), 32'sd0);
    check("reset_busy6", 32'(b6r), 32'sd0);
    check("reset_y1", 32'(y1l), 32'sd0);
    check("reset_valid1", 32'(v1l), 32'sd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run6(tbl[i]);
    end

    // Backpressure: result held, starts ignored while DONE.
    ready6 = 1'b0;
    start6_pulse(tbl[0].x);
    wait_valid6(e);
    check("bp_latency", e, 32'sd7);
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      x6 = tbl[2].x;
      start6 = 1'b1;
      @(negedge clk);
      if (y6r !== 8'sd32 || v6r !== 1'b1 || b6r !== 1'b1) stable = 1'b0;
    end
    start6 = 1'b0;
    check("bp_stable", 32'(stable), 32'sd1);
    // Handshake must not complete while En is low.
    en = 1'b0;
    ready6 = 1'b1;
    repeat (2) @(negedge clk);
    check("en_low_hold_valid", 32'(v6r), 32'sd1);
    // Start together with y_ready in DONE: only the return to IDLE happens.
    en = 1'b1;
    x6 = tbl[7].x;
    start6 = 1'b1;
    @(negedge clk);
    check("done_start_ignored_valid", 32'(v6r), 32'sd0);
    check("done_start_ignored_busy", 32'(b6r), 32'sd0);
    @(negedge clk);
    start6 = 1'b0;
    check("restart_accepted", 32'(b6r), 32'sd1);
    wait_valid6(e);
    check("restart_latency", e, 32'sd7);
    check("restart_y", 32'(y6r), 32'sd5);
    @(negedge clk);

    // Stall: En low for three cycles during MAC.
    start6_pulse(tbl[0].x);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("stall_no_valid", 32'(v6r), 32'sd0);
    en = 1'b1;
    wait_valid6(e);
    check("stall_latency", e + 5, 32'sd10);
    check("stall_y", 32'(y6r), 32'sd32);
    @(negedge clk);

    // Reset in the middle of MAC.
    start6_pulse(tbl[1].x);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(b6r), 32'sd0);
    check("midrst_valid", 32'(v6r), 32'sd0);
    check("midrst_y_relu", 32'(y6r), 32'sd0);
    check("midrst_y_linear", 32'(y6l), 32'sd0);
    repeat (3) @(negedge clk);
    check("midrst_no_partial", 32'(v6r), 32'sd0);
    run6(tbl[0]);

    // Single-input neuron.
    run1(8'hEC, 0, -20);
    run1(8'd127, 127, 127);
    run1(8'h80, 0, -128);
    run1(8'd20, 20, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
